// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_OWN} uart_arb_state_e;

  localparam int UART_BYTE_W = 8;

  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after start, wrapping upward.
module rr_picker #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] start,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int SUM_W = IDX_W + 1;

  always_comb begin
    logic             found;
    logic [SUM_W-1:0] sum;
    logic [IDX_W-1:0] pos;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, start} + SUM_W'(k);
      pos = (sum >= SUM_W'(NUM_REQ)) ? IDX_W'(sum - SUM_W'(NUM_REQ)) : IDX_W'(sum);
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one UART TX engine among several
// byte producers, with a watchdog that revokes a lock from a stalled owner.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]             req_last_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic                           tx_valid_o,
  output logic [UART_BYTE_W-1:0]         tx_data_o,
  input  logic                           tx_ready_i,
  output logic                           grant_o,
  output logic [$clog2(NUM_REQ)-1:0]     owner_o,
  output logic                           timeout_o
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  // Firing when the pre-increment count equals LOCK_TIMEOUT-2 means the count
  // reaches LOCK_TIMEOUT-1 in that cycle, so the pulse lands LOCK_TIMEOUT cycles
  // after the owner's last transfer.
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(LOCK_TIMEOUT - 2);

  uart_arb_state_e        state;
  logic [IDX_W-1:0]       owner;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       pick_idx;
  logic [NUM_REQ-1:0]     pick_gnt;
  logic                   pick_any;
  logic [CNT_W-1:0]       idle_cnt;
  logic                   grant_q;
  logic                   timeout_q;
  logic                   own;
  logic                   own_valid;
  logic                   own_last;
  logic [UART_BYTE_W-1:0] own_data;
  logic                   xfer;
  logic                   counting;
  logic                   wd_fire;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (req_valid_i),
    .start (rr_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx)
  );

  assign pick_any  = |pick_gnt;
  assign own       = (state == ARB_OWN);
  assign own_valid = req_valid_i[owner];
  assign own_last  = req_last_i[owner];
  assign own_data  = req_data_i[{owner, 3'b000} +: UART_BYTE_W];
  assign xfer      = own && own_valid && tx_ready_i;
  // Backpressure with valid held high is not a stall, so only a missing byte counts.
  assign counting  = own && !own_valid;
  assign wd_fire   = counting && (idle_cnt == CNT_FIRE);

  always_comb begin
    req_ready_o = '0;
    if (own) req_ready_o[owner] = tx_ready_i;
  end

  assign tx_valid_o = own && own_valid;
  assign tx_data_o  = own ? own_data : '0;
  assign grant_o    = grant_q;
  assign owner_o    = owner;
  assign timeout_o  = timeout_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ARB_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      idle_cnt  <= '0;
      grant_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            state    <= ARB_OWN;
            owner    <= pick_idx;
            grant_q  <= 1'b1;
            idle_cnt <= '0;
          end
        end
        ARB_OWN: begin
          if (xfer) begin
            idle_cnt <= '0;
            if (own_last) begin
              state   <= ARB_IDLE;
              grant_q <= 1'b0;
              rr_ptr  <= IDX_W'(next_idx(32'(owner), NUM_REQ));
            end
          end else if (wd_fire) begin
            state     <= ARB_IDLE;
            grant_q   <= 1'b0;
            timeout_q <= 1'b1;
            idle_cnt  <= '0;
            rr_ptr    <= IDX_W'(next_idx(32'(owner), NUM_REQ));
          end else if (counting) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic, all
// checked cycle by cycle against a message-level reference model.
module tb_uart_tx_arbiter;
  localparam int N  = 3;
  localparam int LT = 16;
  localparam int IW = $clog2(N);

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [N-1:0]  req_valid_i;
  logic [N*8-1:0] req_data_i;
  logic [N-1:0]  req_last_i;
  logic [N-1:0]  req_ready_o;
  logic          tx_valid_o;
  logic [7:0]    tx_data_o;
  logic          tx_ready_i;
  logic          grant_o;
  logic [IW-1:0] owner_o;
  logic          timeout_o;

  always #5 clk_i = ~clk_i;

  uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(LT)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_valid_o  (tx_valid_o),
    .tx_data_o   (tx_data_o),
    .tx_ready_i  (tx_ready_i),
    .grant_o     (grant_o),
    .owner_o     (owner_o),
    .timeout_o   (timeout_o)
  );

  typedef struct {
    int         cyc;
    int         own;
    logic [7:0] data;
    logic       last;
  } xfer_t;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  logic [8:0] pq [N][$];
  logic [N-1:0] hold;
  xfer_t      xlog[$];
  int         tlog[$];

  // Reference model: who holds the transmitter, where the next search starts,
  // how many stalled cycles the holder has used, and the pending revoke pulse.
  bit m_busy, m_tmo;
  int m_owner, m_start, m_idle;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += pq[i].size();
    return s;
  endfunction

  task automatic push_byte(input int p, input logic [7:0] b, input logic last);
    pq[p].push_back({last, b});
  endtask

  task automatic push_msg(input int p, input int len);
    for (int k = 0; k < len; k++) push_byte(p, 8'($urandom_range(0, 255)), k == len - 1);
  endtask

  task automatic drive();
    logic [8:0] h;
    for (int i = 0; i < N; i++) begin
      if (pq[i].size() > 0 && !hold[i]) begin
        h = pq[i][0];
        req_valid_i[i]        = 1'b1;
        req_data_i[i*8 +: 8]  = h[7:0];
        req_last_i[i]         = h[8];
      end else begin
        req_valid_i[i]        = 1'b0;
        req_data_i[i*8 +: 8]  = 8'h00;
        req_last_i[i]         = 1'b0;
      end
    end
  endtask

  function automatic void model_update();
    bit found = 0;
    m_tmo = 0;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        int j = (m_start + k) % N;
        if (!found && req_valid_i[j]) begin
          found = 1; m_busy = 1; m_owner = j; m_idle = 0;
        end
      end
    end else if (req_valid_i[m_owner]) begin
      if (tx_ready_i) begin
        m_idle = 0;
        if (req_last_i[m_owner]) begin
          m_busy = 0; m_start = (m_owner + 1) % N;
        end
      end
    end else begin
      m_idle++;
      if (m_idle >= LT - 1) begin
        m_busy = 0; m_tmo = 1; m_idle = 0; m_start = (m_owner + 1) % N;
      end
    end
  endfunction

  // One clock cycle: drive, compare away from the edge, advance model and producers.
  task automatic step();
    logic [N-1:0] e_ready;
    logic [N-1:0] popm;
    xfer_t        e;
    drive();
    #1;
    e_ready = '0;
    if (m_busy && tx_ready_i) e_ready[m_owner] = 1'b1;
    check_val("grant", 32'(grant_o), 32'(m_busy));
    check_val("timeout", 32'(timeout_o), 32'(m_tmo));
    check_val("ready", 32'(req_ready_o), 32'(e_ready));
    check_val("tx_valid", 32'(tx_valid_o), 32'(m_busy && req_valid_i[m_owner]));
    if (m_busy) begin
      check_val("owner", 32'(owner_o), 32'(m_owner));
      check_val("tx_data", 32'(tx_data_o), 32'(req_data_i[m_owner*8 +: 8]));
    end
    if (tx_valid_o && tx_ready_i) begin
      e.cyc = cyc; e.own = int'(owner_o); e.data = tx_data_o; e.last = req_last_i[owner_o];
      xlog.push_back(e);
    end
    if (timeout_o) tlog.push_back(cyc);
    popm = req_valid_i & req_ready_o;
    model_update();
    @(posedge clk_i);
    for (int i = 0; i < N; i++) if (popm[i]) void'(pq[i].pop_front());
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic run_until_drained(input int budget);
    int n = 0;
    while ((pending() > 0 || m_busy) && n < budget) begin
      step();
      n++;
    end
    check_val("drain", 32'(pending()), 32'd0);
  endtask

  // Asserts reset wherever called, checks outputs at once, leaves rst_ni low at a negedge.
  task automatic apply_reset(input int cycles);
    rst_ni = 1'b0;
    #1;
    check_val("rst_ready", 32'(req_ready_o), 32'd0);
    check_val("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    check_val("rst_tx_data", 32'(tx_data_o), 32'd0);
    check_val("rst_grant", 32'(grant_o), 32'd0);
    check_val("rst_owner", 32'(owner_o), 32'd0);
    check_val("rst_timeout", 32'(timeout_o), 32'd0);
    for (int i = 0; i < N; i++) pq[i].delete();
    hold = '0;
    drive();
    m_busy = 0; m_tmo = 0; m_owner = 0; m_start = 0; m_idle = 0;
    xlog.delete();
    tlog.delete();
    repeat (cycles) @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    int         c0;
    int         rise;
    int         hold_cnt[N];
    logic [7:0] exp_hi[3];
    logic [7:0] exp_ab[4];
    int         exp_ab_own[4];
    exp_hi = '{8'h68, 8'h69, 8'h0A};
    exp_ab = '{8'h41, 8'h0A, 8'h42, 8'h0A};
    exp_ab_own = '{0, 0, 1, 1};
    rst_ni = 1'b1;
    req_valid_i = '0; req_data_i = '0; req_last_i = '0;
    tx_ready_i = 1'b0; hold = '0;
    #2;

    // Single producer "hi\n"
    apply_reset(2);
    push_byte(0, 8'h68, 0); push_byte(0, 8'h69, 0); push_byte(0, 8'h0A, 1);
    tx_ready_i = 1'b1;
    rst_ni = 1'b1;
    c0 = cyc;
    run_until_drained(50);
    repeat (2) step();
    check_val("hi_count", 32'(xlog.size()), 32'd3);
    for (int k = 0; k < 3 && k < xlog.size(); k++) begin
      check_val($sformatf("hi_data%0d", k), 32'(xlog[k].data), 32'(exp_hi[k]));
      check_val($sformatf("hi_cyc%0d", k), 32'(xlog[k].cyc), 32'(c0 + 1 + k));
    end

    // Contention from reset release
    apply_reset(2);
    push_byte(0, 8'h41, 0); push_byte(0, 8'h0A, 1);
    push_byte(1, 8'h42, 0); push_byte(1, 8'h0A, 1);
    rst_ni = 1'b1;
    run_until_drained(50);
    check_val("ab_count", 32'(xlog.size()), 32'd4);
    for (int k = 0; k < 4 && k < xlog.size(); k++) begin
      check_val($sformatf("ab_own%0d", k), 32'(xlog[k].own), 32'(exp_ab_own[k]));
      check_val($sformatf("ab_data%0d", k), 32'(xlog[k].data), 32'(exp_ab[k]));
    end
    if (xlog.size() >= 3) check_val("ab_gap", 32'(xlog[2].cyc - xlog[1].cyc), 32'd2);

    // Fairness with continuous 1-byte messages
    apply_reset(2);
    for (int k = 0; k < 4; k++) begin
      push_byte(0, 8'(8'h10 + k), 1);
      push_byte(1, 8'(8'h20 + k), 1);
    end
    rst_ni = 1'b1;
    run_until_drained(100);
    check_val("fair_count", 32'(xlog.size()), 32'd8);
    for (int k = 0; k < xlog.size(); k++) begin
      check_val($sformatf("fair_own%0d", k), 32'(xlog[k].own), 32'(k % 2));
      if (k > 0) check_val($sformatf("fair_gap%0d", k), 32'(xlog[k].cyc - xlog[k-1].cyc), 32'd2);
    end

    // Long backpressure is not a stall
    apply_reset(2);
    push_byte(1, 8'h55, 1);
    tx_ready_i = 1'b0;
    rst_ni = 1'b1;
    repeat (2000) step();
    tx_ready_i = 1'b1;
    rise = cyc;
    repeat (2) step();
    check_val("bp_timeouts", 32'(tlog.size()), 32'd0);
    check_val("bp_count", 32'(xlog.size()), 32'd1);
    if (xlog.size() >= 1) begin
      check_val("bp_cyc", 32'(xlog[0].cyc), 32'(rise));
      check_val("bp_own", 32'(xlog[0].own), 32'd1);
    end

    // Watchdog revokes a stalled owner
    apply_reset(2);
    push_byte(0, 8'h30, 0);
    push_byte(1, 8'h31, 1);
    tx_ready_i = 1'b1;
    rst_ni = 1'b1;
    run_until_drained(100);
    repeat (2) step();
    check_val("wd_pulses", 32'(tlog.size()), 32'd1);
    check_val("wd_count", 32'(xlog.size()), 32'd2);
    if (tlog.size() >= 1 && xlog.size() >= 2) begin
      check_val("wd_own0", 32'(xlog[0].own), 32'd0);
      check_val("wd_delay", 32'(tlog[0] - xlog[0].cyc), 32'(LT));
      check_val("wd_own1", 32'(xlog[1].own), 32'd1);
      check_val("wd_regrant", 32'(xlog[1].cyc), 32'(tlog[0] + 1));
    end

    // Reset in the middle of a message
    apply_reset(2);
    for (int k = 0; k < 4; k++) push_byte(0, 8'(8'h60 + k), k == 3);
    push_byte(1, 8'h70, 1);
    rst_ni = 1'b1;
    repeat (2) step();
    drive();
    #2;
    apply_reset(2);
    push_byte(1, 8'h71, 1);
    rst_ni = 1'b1;
    run_until_drained(50);
    check_val("mid_count", 32'(xlog.size()), 32'd1);
    if (xlog.size() >= 1) check_val("mid_own", 32'(xlog[0].own), 32'd1);

    // Random traffic with random backpressure and producer stalls
    for (int i = 0; i < N; i++) hold_cnt[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 15) == 0 && pq[i].size() < 6) push_msg(i, int'($urandom_range(1, 4)));
        if (hold_cnt[i] > 0) begin
          hold_cnt[i]--;
          hold[i] = 1'b1;
        end else begin
          hold[i] = 1'b0;
          if ($urandom_range(0, 63) == 0) hold_cnt[i] = int'($urandom_range(1, 30));
        end
      end
      tx_ready_i = ($urandom_range(0, 3) != 0);
      step();
    end
    hold = '0;
    tx_ready_i = 1'b1;
    run_until_drained(500);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
